timer_counter: RTL
==================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL provide parameter W, default 32, meaning width of the PRESET and COUNT registers (1..32); narrower values are zero-extended on rdata.
REQ-002 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL provide port addr  input  2  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
REQ-005 SHALL provide port we  input  1  write strobe from the CPU data-memory bridge, sampled on the clk edge.
REQ-006 SHALL provide port wdata  input  32  write data.
REQ-007 SHALL provide port rdata  output  32  combinational read of the register selected by addr.
REQ-008 SHALL provide port irq  output  1  interrupt request to the CPU; equals irq_flag AND CTRL.IM.

Function
REQ-009 CTRL SHALL hold 4 bits: [0] EN (enable), [2:1] MODE (00 = one-shot, 01 = auto-reload, 10/11 = treated as 00), [3] IM (interrupt mask).
REQ-010 rdata SHALL be {28'b0, CTRL} for addr 0, zero-extended PRESET for addr 1, zero-extended COUNT for addr 2, and 0 for addr 3.
REQ-011 A CTRL write SHALL load wdata[3:0] into CTRL (wdata[31:4] ignored), clear irq_flag, and force the FSM to IDLE on the same edge; COUNT holds.
REQ-012 A PRESET write SHALL load wdata[W-1:0] into PRESET and SHALL NOT affect COUNT until the next LOAD state.
REQ-013 Writes to addr 2 or addr 3 SHALL be ignored.
REQ-014 FSM SHALL have the states IDLE, LOAD, CNT and INT; in any cycle without a CTRL write, transitions SHALL be as REQ-015 to REQ-018.
REQ-015 IDLE: go to LOAD when EN=1, else stay in IDLE; COUNT holds.
REQ-016 LOAD: COUNT <= PRESET; go to CNT.
REQ-017 CNT: if EN=0, go to IDLE with COUNT held; else if COUNT==0, go to INT and set irq_flag; else COUNT <= COUNT-1.
REQ-018 INT: in one-shot mode, clear EN by hardware and go to IDLE, with irq_flag held until the next CTRL write; in auto-reload mode, go to LOAD and clear irq_flag, giving a one-cycle flag.
REQ-019 Latency: after a write enabling the timer with PRESET=N, irq_flag SHALL rise on the (N+3)th following edge; the auto-reload period SHALL be N+3 cycles.
REQ-020 PRESET=0 SHALL enter INT on the edge after LOAD, with no underflow.
REQ-021 COUNT SHALL never wrap below 0.
REQ-022 A simultaneous CTRL write and COUNT==0 in CNT SHALL give precedence to the write: irq_flag stays 0 and the FSM goes to IDLE.
REQ-023 IM=0 SHALL mask irq while irq_flag still sets; setting IM later via a CTRL write also clears the flag (REQ-011).

Reset
REQ-024 While reset=0, regardless of clk: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0, and rdata=0 for all addr values.
REQ-025 Reset asserted mid-count SHALL abort immediately; after release the block SHALL stay in IDLE until EN is written to 1.

Configuration
REQ-026 Macro TIMER_AUTORELOAD_EN: when defined, MODE=01 SHALL behave as auto-reload per REQ-018.
REQ-027 Without TIMER_AUTORELOAD_EN, MODE=01 SHALL behave as one-shot, and CTRL[2:1] SHALL still store and read back the written value.

Verification
REQ-028 Reset: hold reset=0 for 3 cycles with we=1 and wdata=32'hFFFFFFFF -> all reads return 0 and irq=0.
REQ-029 One-shot: write PRESET=5, then CTRL=4'b1001 -> irq rises exactly 8 edges after the CTRL write edge, CTRL reads 4'b1000, irq stays high until CTRL is written with 0, then irq=0 on the next edge.
REQ-030 Auto-reload (macro defined): write PRESET=2, then CTRL=4'b1011 -> irq is a one-cycle pulse every 5 cycles for at least 4 pulses; with the macro undefined -> a single pulse, then EN=0.
REQ-031 Collision: write CTRL=4'b1001 on the exact edge where COUNT==0 in CNT -> irq never rises, the FSM restarts via IDLE/LOAD, and COUNT reloads to PRESET.
REQ-032 Edge cases: PRESET=0 with EN=1 -> irq 3 edges after the write; IM=0 -> irq stays 0 while the internal flag sets; a write to addr 2 leaves COUNT unchanged; addr 3 reads 0.
REQ-033 Reset mid-count: assert reset with COUNT=3 -> COUNT=0 and state=IDLE immediately, and no irq appears after release.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers and an IDLE/LOAD/CNT/INT FSM.
// Optional feature: define TIMER_AUTORELOAD_EN to make MODE=01 reload automatically after each expiry.
module timer_counter #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     ctrl_q, ctrl_d;
    logic [W-1:0]   preset_q, preset_d;
    logic [W-1:0]   count_q, count_d;
    logic           flag_q, flag_d;
    logic           wr_ctrl, wr_preset, auto_reload;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // A CTRL write overrides whatever the FSM would have done on this edge.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        if (wr_ctrl) begin
            ctrl_d  = wdata[3:0];
            flag_d  = 1'b0;
            state_d = IDLE;
        end else begin
            if (wr_preset) begin
                preset_d = wdata[W-1:0];
            end
            case (state_q)
                IDLE: begin
                    if (ctrl_q[0]) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    count_d = preset_q;
                    state_d = CNT;
                end
                CNT: begin
                    if (!ctrl_q[0]) begin
                        state_d = IDLE;
                    end else if (count_q == '0) begin
                        state_d = INT;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = count_q - W'(1);
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state_d = LOAD;
                        flag_d  = 1'b0;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, ctrl_q};
            2'd1:    rdata = 32'(preset_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = 32'd0;
        endcase
    end

    assign irq = flag_q & ctrl_q[3];

endmodule
